// File: rtl/ula_control.sv
// ula_control
//   Multi-cycle control unit for the 16-bit ALU datapath. On Run it captures
//   an instruction from DIN in T0. It then walks through T1..T3 and drives
//   the datapath controls for the current step: the bus source, the register
//   write strobes, the A/G latch loads and the ALU operation code.
//
// Ports
//   Clock  in  1      rising-edge clock
//   Reset  in  1      asynchronous active-high reset (returns to T0, IR=0)
//   Run    in  1      start request, sampled only in T0
//   DIN    in  16     instruction word in T0 / immediate in MVI T1
//   Gnz    in  1      datapath G is non-zero, used only in MVNZ T1
//   Rsel   out 4      bus source: 0-7 = R0-R7, 8 = DIN, 9 = G, 15 = none
//   Rin    out NREGS  one-hot register write enable
//   Ain    out 1      load ALU operand latch A from the bus
//   Gin    out 1      load result latch G from the ALU
//   ulaOp  out 4      ALU operation code (non-zero only in T2)
//   Done   out 1      last cycle of the current instruction
//   Busy   out 1      high in every state except T0

module ula_control #(
  parameter int NREGS = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Run,
  input  logic [15:0]      DIN,
  input  logic             Gnz,
  output logic [3:0]       Rsel,
  output logic [NREGS-1:0] Rin,
  output logic             Ain,
  output logic             Gin,
  output logic [3:0]       ulaOp,
  output logic             Done,
  output logic             Busy
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } stateType;

  localparam logic [3:0] OP_MV   = 4'b0000;
  localparam logic [3:0] OP_MVI  = 4'b0001;
  localparam logic [3:0] OP_MVNZ = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SLL  = 4'b1010;

  localparam logic [3:0] SEL_DIN  = 4'd8;
  localparam logic [3:0] SEL_G    = 4'd9;
  localparam logic [3:0] SEL_NONE = 4'd15;

  stateType   state;
  stateType   nextState;
  logic [15:0] ir;

  logic [3:0]       opcode;
  logic [2:0]       rx;
  logic [2:0]       ry;
  logic             isAluOp;
  logic [NREGS-1:0] rxOneHot;

  // The low six instruction bits carry no meaning; folding them into an
  // "unused" net keeps them visible as deliberately ignored.
  logic unusedIrBits;
  assign unusedIrBits = ^ir[5:0];

  assign opcode = ir[15:12];
  assign rx     = ir[11:9];
  assign ry     = ir[8:6];

  // Classify the latched opcode once so the state decode below stays flat.
  always_comb begin
    isAluOp = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_OR, OP_SLT, OP_SRL, OP_SLL: isAluOp = 1'b1;
      default:                                       isAluOp = 1'b0;
    endcase
  end

  // One-hot write strobe for Rx. A register index at or beyond NREGS simply
  // produces no strobe.
  always_comb begin
    rxOneHot = '0;
    for (int i = 0; i < NREGS; i++) begin
      rxOneHot[i] = (int'(rx) == i);
    end
  end

  // State and instruction registers. IR loads only on an accepted fetch, so
  // DIN is free to carry the MVI immediate while the instruction runs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= nextState;
      if (state == T0 && Run) begin
        ir <= DIN;
      end
    end
  end

  // Next-state and output decode. The outputs depend only on the state and
  // IR, plus Gnz in MVNZ T1. Run and DIN never reach an output
  // combinationally.
  always_comb begin
    nextState = state;
    Rsel      = SEL_NONE;
    Rin       = '0;
    Ain       = 1'b0;
    Gin       = 1'b0;
    ulaOp     = 4'b0000;
    Done      = 1'b0;
    Busy      = (state != T0);

    case (state)
      T0: begin
        if (Run) nextState = T1;
      end

      T1: begin
        nextState = T0;
        if (isAluOp) begin
          Rsel      = {1'b0, rx};
          Ain       = 1'b1;
          nextState = T2;
        end else begin
          Done = 1'b1;
          case (opcode)
            OP_MV: begin
              Rsel = {1'b0, ry};
              Rin  = rxOneHot;
            end
            OP_MVI: begin
              Rsel = SEL_DIN;
              Rin  = rxOneHot;
            end
            OP_MVNZ: begin
              if (Gnz) begin
                Rsel = {1'b0, ry};
                Rin  = rxOneHot;
              end
            end
            default: ;
          endcase
        end
      end

      T2: begin
        Rsel      = {1'b0, ry};
        ulaOp     = opcode;
        Gin       = 1'b1;
        nextState = T3;
      end

      T3: begin
        Rsel      = SEL_G;
        Rin       = rxOneHot;
        Done      = 1'b1;
        nextState = T0;
      end

      default: nextState = T0;
    endcase
  end

endmodule

// File: tb/tb_ula_control.sv
// tb_ula_control
//   Scoreboard bench for ula_control. Each issued instruction pushes its
//   expected per-cycle control outputs. A record covers every cycle after
//   the fetch edge, including the return to T0. The records are popped and
//   compared one cycle at a time, shortly after each rising edge.

module tb_ula_control;

  logic        Clock;
  logic        Reset;
  logic        Run;
  logic [15:0] DIN;
  logic        Gnz;
  logic [3:0]  Rsel;
  logic [7:0]  Rin;
  logic        Ain;
  logic        Gin;
  logic [3:0]  ulaOp;
  logic        Done;
  logic        Busy;

  typedef struct {
    string      tag;
    logic [3:0] rsel;
    logic [7:0] rin;
    logic       ain;
    logic       gin;
    logic [3:0] ulaop;
    logic       done;
    logic       busy;
  } expRec;

  expRec sb[$];

  int checks = 0;
  int errors = 0;
  int doneCount = 0;

  ula_control #(.NREGS(8)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Run  (Run),
    .DIN  (DIN),
    .Gnz  (Gnz),
    .Rsel (Rsel),
    .Rin  (Rin),
    .Ain  (Ain),
    .Gin  (Gin),
    .ulaOp(ulaOp),
    .Done (Done),
    .Busy (Busy)
  );

  // Free-running 10-unit clock.
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Hard time limit so a stuck run still terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic expRec idleRec(input string tag);
    expRec r;
    r.tag   = tag;
    r.rsel  = 4'd15;
    r.rin   = 8'd0;
    r.ain   = 1'b0;
    r.gin   = 1'b0;
    r.ulaop = 4'd0;
    r.done  = 1'b0;
    r.busy  = 1'b0;
    return r;
  endfunction

  // Reference sequencing: expands one instruction into its cycle-by-cycle
  // control pattern, ending with the idle T0 cycle that follows Done.
  task automatic pushExpected(input logic [15:0] instr, input logic gnz);
    logic [3:0] op;
    logic [2:0] rx;
    logic [2:0] ry;
    logic [7:0] wr;
    expRec      r;
    op = instr[15:12];
    rx = instr[11:9];
    ry = instr[8:6];
    wr = 8'd1 << rx;

    r      = idleRec($sformatf("%h.T1", instr));
    r.busy = 1'b1;
    if (op >= 4'd5 && op <= 4'd10) begin
      r.rsel = {1'b0, rx};
      r.ain  = 1'b1;
      sb.push_back(r);

      r       = idleRec($sformatf("%h.T2", instr));
      r.busy  = 1'b1;
      r.rsel  = {1'b0, ry};
      r.ulaop = op;
      r.gin   = 1'b1;
      sb.push_back(r);

      r      = idleRec($sformatf("%h.T3", instr));
      r.busy = 1'b1;
      r.rsel = 4'd9;
      r.rin  = wr;
      r.done = 1'b1;
      sb.push_back(r);
    end else begin
      r.done = 1'b1;
      if (op == 4'd0 || (op == 4'd2 && gnz)) begin
        r.rsel = {1'b0, ry};
        r.rin  = wr;
      end else if (op == 4'd1) begin
        r.rsel = 4'd8;
        r.rin  = wr;
      end
      sb.push_back(r);
    end
    sb.push_back(idleRec($sformatf("%h.end", instr)));
  endtask

  // Pops one expected record and compares it with the current outputs.
  task automatic checkCycle();
    expRec r;
    if (sb.size() == 0) begin
      checkOutput("scoreboardEmpty", 16'(sb.size()), 16'd1);
      return;
    end
    r = sb.pop_front();
    if (Done) doneCount++;
    checkOutput({r.tag, ".Rsel"},  16'(Rsel),  16'(r.rsel));
    checkOutput({r.tag, ".Rin"},   16'(Rin),   16'(r.rin));
    checkOutput({r.tag, ".Ain"},   16'(Ain),   16'(r.ain));
    checkOutput({r.tag, ".Gin"},   16'(Gin),   16'(r.gin));
    checkOutput({r.tag, ".ulaOp"}, 16'(ulaOp), 16'(r.ulaop));
    checkOutput({r.tag, ".Done"},  16'(Done),  16'(r.done));
    checkOutput({r.tag, ".Busy"},  16'(Busy),  16'(r.busy));
  endtask

  // Issues one instruction from T0, and keeps Run high afterwards when
  // holdRun is set. DIN carries imm after the fetch edge. The scoreboard is
  // drained one cycle per edge. The loop is bounded by the record count.
  task automatic applyStimulus(input logic [15:0] instr, input logic [15:0] imm,
                               input logic gnz, input logic holdRun);
    pushExpected(instr, gnz);
    DIN = instr;
    Gnz = gnz;
    Run = 1'b1;
    @(posedge Clock);
    #1;
    checkCycle();
    Run = holdRun;
    DIN = imm;
    while (sb.size() > 0) begin
      @(posedge Clock);
      #1;
      checkCycle();
    end
  endtask

  initial begin
    logic sawActivity;
    Reset = 1'b1;
    Run   = 1'b1;
    DIN   = 16'h5280;
    Gnz   = 1'b0;

    // Reset held with Run high: everything stays at reset values.
    repeat (2) @(posedge Clock);
    #1;
    checkOutput("reset.Rsel",  16'(Rsel),  16'd15);
    checkOutput("reset.Rin",   16'(Rin),   16'd0);
    checkOutput("reset.Ain",   16'(Ain),   16'd0);
    checkOutput("reset.Gin",   16'(Gin),   16'd0);
    checkOutput("reset.ulaOp", 16'(ulaOp), 16'd0);
    checkOutput("reset.Done",  16'(Done),  16'd0);
    checkOutput("reset.Busy",  16'(Busy),  16'd0);

    // Release reset: the next edge fetches ADD R1,R2 directly.
    Reset = 1'b0;
    applyStimulus(16'h5280, 16'h0000, 1'b0, 1'b0);

    // MVNZ R7,R0 with G zero and with G non-zero.
    applyStimulus(16'h2E00, 16'h0000, 1'b0, 1'b0);
    applyStimulus(16'h2E00, 16'h0000, 1'b1, 1'b0);
    Gnz = 1'b0;

    // MVI R2 then MV R3,R2 back-to-back, with Run held high throughout.
    doneCount = 0;
    applyStimulus(16'h1400, 16'h00A5, 1'b0, 1'b1);
    applyStimulus(16'h0680, 16'h0000, 1'b0, 1'b0);
    checkOutput("b2b.doneCount", 16'(doneCount), 16'd2);

    // Illegal opcodes behave as single-cycle NOPs.
    applyStimulus(16'h3000, 16'h0000, 1'b0, 1'b0);
    applyStimulus(16'h4C40, 16'h0000, 1'b0, 1'b0);
    applyStimulus(16'hF1C0, 16'h0000, 1'b0, 1'b0);

    // All six ALU opcodes with varied registers, plus Rx = Ry.
    for (int op = 5; op <= 10; op++) begin
      logic [15:0] instr;
      instr = {4'(op), 3'(op), 3'(op + 3), 6'h15};
      applyStimulus(instr, 16'hFFFF, 1'b1, 1'b0);
    end
    applyStimulus(16'h56C0, 16'h0000, 1'b0, 1'b0);

    // Reset during T2 of SUB aborts the instruction immediately.
    DIN = 16'h6400;
    Run = 1'b1;
    pushExpected(16'h6400, 1'b0);
    @(posedge Clock);
    #1;
    checkCycle();
    Run = 1'b0;
    @(posedge Clock);
    #1;
    checkCycle();
    sb.delete();
    #1;
    Reset = 1'b1;
    #1;
    checkOutput("abort.Gin",   16'(Gin),   16'd0);
    checkOutput("abort.Rsel",  16'(Rsel),  16'd15);
    checkOutput("abort.ulaOp", 16'(ulaOp), 16'd0);
    checkOutput("abort.Busy",  16'(Busy),  16'd0);
    @(negedge Clock);
    Reset = 1'b0;
    sawActivity = 1'b0;
    repeat (4) begin
      @(posedge Clock);
      #1;
      sawActivity = sawActivity | Done | Gin | (|Rin) | Busy;
    end
    checkOutput("abort.noFollowup", 16'(sawActivity), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
